// File: rtl/shift_mix_key_stage_pkg.sv
// Shared AES round constants, datapath typedefs and the GF(2^8) doubling helper
// used by the ShiftRows/MixColumns/AddRoundKey stage.
package shift_mix_key_stage_pkg;

   localparam logic [3:0] NUM_ROUNDS = 4'd10;
   localparam logic [7:0] GF_POLY    = 8'h1B;

   typedef logic [127:0] state_t;
   typedef logic [31:0]  col_t;

   // Multiply by x in GF(2^8), reducing by the AES polynomial on overflow.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/shift_mix_key_stage_mix_column.sv
// MixColumns on one 32-bit column (row0 in [31:24]) using the circulant
// matrix {02 03 01 01}.
module mix_column
   import shift_mix_key_stage_pkg::*;
(
   input  col_t i_col,
   output col_t o_col
);

   logic [7:0] w_a0, w_a1, w_a2, w_a3;
   logic [7:0] w_x0, w_x1, w_x2, w_x3;

   assign {w_a0, w_a1, w_a2, w_a3} = i_col;

   assign w_x0 = xtime(w_a0);
   assign w_x1 = xtime(w_a1);
   assign w_x2 = xtime(w_a2);
   assign w_x3 = xtime(w_a3);

   // 03*a is xtime(a) ^ a.
   assign o_col[31:24] = w_x0 ^ w_x1 ^ w_a1 ^ w_a2 ^ w_a3;
   assign o_col[23:16] = w_a0 ^ w_x1 ^ w_x2 ^ w_a2 ^ w_a3;
   assign o_col[15:8]  = w_a0 ^ w_a1 ^ w_x2 ^ w_x3 ^ w_a3;
   assign o_col[7:0]   = w_x0 ^ w_a0 ^ w_a1 ^ w_a2 ^ w_x3;

endmodule

// File: rtl/shift_mix_key_stage.sv
// AES round back half: ShiftRows, MixColumns (skipped on the final round) and
// AddRoundKey, with one valid/ready output register and a round counter.
module shift_mix_key_stage
   import shift_mix_key_stage_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] sub_state,
   input  logic [127:0] round_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         out_last,
   output logic [3:0]   round_idx
);

   state_t     w_shift;
   state_t     w_mix;
   state_t     w_result;
   logic       w_accept;
   logic       w_final;

   state_t     r_out_state;
   logic       r_out_valid;
   logic       r_out_last;
   logic [3:0] r_round_idx;

   // Byte (row r, col c) sits at bits [127-8*(4c+r) -: 8]; row r rotates left by r.
   always_comb begin
      w_shift = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            w_shift[127 - 8*(4*c + r) -: 8] = sub_state[127 - 8*(4*((c + r) % 4) + r) -: 8];
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_mix
      mix_column u_mix_column (
         .i_col (w_shift[127 - 32*g -: 32]),
         .o_col (w_mix[127 - 32*g -: 32])
      );
   end

   assign w_final  = (r_round_idx == NUM_ROUNDS);
   assign w_result = (w_final ? w_shift : w_mix) ^ round_key;
   assign in_ready = !r_out_valid || out_ready;
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_state <= 128'h0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_round_idx <= 4'd1;
      end else if (w_accept) begin
         r_out_state <= w_result;
         r_out_valid <= 1'b1;
         r_out_last  <= w_final;
         r_round_idx <= w_final ? 4'd1 : r_round_idx + 4'd1;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= r_out_valid;
      end
   end

   assign out_state = r_out_state;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign round_idx = r_round_idx;

endmodule

// File: tb/tb_shift_mix_key_stage.sv
// Directed bench for shift_mix_key_stage: FIPS-197 round vectors, uniform-byte
// rounds, backpressure, mid-block reset and 20-beat streaming.
module tb_shift_mix_key_stage;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] sub_state = 128'h0;
   logic [127:0] round_key = 128'h0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] out_state;
   logic         out_last;
   logic [3:0]   round_idx;

   logic [31:0]  mc_in = 32'h0;
   logic [31:0]  mc_out;

   int n_checks = 0;
   int n_fails  = 0;

   localparam logic [127:0] R1_SUB  = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] R1_KEY  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] R1_OUT  = 128'ha49c7ff2689f352b6b5bea43026a5049;
   localparam logic [127:0] R10_SUB = 128'he9098972cb31075f3d327d94af2e2cb5;
   localparam logic [127:0] R10_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] R10_OUT = 128'h3925841d02dc09fbdc118597196a0b32;

   shift_mix_key_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sub_state (sub_state),
      .round_key (round_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .out_last  (out_last),
      .round_idx (round_idx)
   );

   mix_column u_mc (
      .i_col (mc_in),
      .o_col (mc_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] b;

      // Asynchronous reset before any clock edge
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 128'd0);
      chk("rst_out_last", out_last, 128'd0);
      chk("rst_out_state", out_state, 128'h0);
      chk("rst_round_idx", round_idx, 128'd1);
      step();
      step();
      rst = 1'b0;
      step();
      chk("post_rst_in_ready", in_ready, 128'd1);

      // MixColumns unit
      mc_in = 32'hdb135345; #1;
      chk("mc_db135345", mc_out, 128'h8e4da1bc);
      mc_in = 32'hf20a225c; #1;
      chk("mc_f20a225c", mc_out, 128'h9fdc589d);
      mc_in = 32'h01010101; #1;
      chk("mc_01010101", mc_out, 128'h01010101);

      // Ten-round block: FIPS round 1, uniform rounds 2..9, FIPS round 10
      out_ready = 1'b1;
      in_valid  = 1'b1;
      sub_state = R1_SUB;
      round_key = R1_KEY;
      step();
      chk("r1_out_valid", out_valid, 128'd1);
      chk("r1_out_state", out_state, R1_OUT);
      chk("r1_out_last", out_last, 128'd0);
      chk("r1_round_idx", round_idx, 128'd2);
      for (int r = 2; r <= 9; r++) begin
         b = {4'(r), 4'(r)};
         sub_state = {16{b}};
         round_key = {16{8'hA5}};
         step();
         chk("mid_out_state", out_state, {16{b ^ 8'hA5}});
         chk("mid_out_last", out_last, 128'd0);
         chk("mid_round_idx", round_idx, 128'(r + 1));
      end
      sub_state = R10_SUB;
      round_key = R10_KEY;
      step();
      chk("r10_out_state", out_state, R10_OUT);
      chk("r10_out_last", out_last, 128'd1);
      chk("r10_round_idx", round_idx, 128'd1);
      in_valid = 1'b0;
      step();
      chk("drain_out_valid", out_valid, 128'd0);
      chk("idle_round_idx", round_idx, 128'd1);

      // Backpressure: first beat accepted, second held off for 5 cycles
      out_ready = 1'b0;
      in_valid  = 1'b1;
      sub_state = {16{8'h11}};
      round_key = 128'h0;
      step();
      chk("bp_first_valid", out_valid, 128'd1);
      chk("bp_in_ready_low", in_ready, 128'd0);
      sub_state = {16{8'h22}};
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold_in_ready", in_ready, 128'd0);
         chk("bp_hold_valid", out_valid, 128'd1);
         chk("bp_hold_state", out_state, {16{8'h11}});
         chk("bp_hold_last", out_last, 128'd0);
         chk("bp_hold_round_idx", round_idx, 128'd2);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", in_ready, 128'd1);
      step();
      chk("bp_swap_valid", out_valid, 128'd1);
      chk("bp_swap_state", out_state, {16{8'h22}});
      chk("bp_swap_round_idx", round_idx, 128'd3);
      in_valid = 1'b0;
      step();
      chk("bp_drain_valid", out_valid, 128'd0);

      // Mid-block reset after round 4
      in_valid  = 1'b1;
      sub_state = {16{8'h33}};
      step();
      sub_state = {16{8'h44}};
      step();
      chk("pre_rst_round_idx", round_idx, 128'd5);
      chk("pre_rst_valid", out_valid, 128'd1);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 128'd0);
      chk("mid_rst_round_idx", round_idx, 128'd1);
      chk("mid_rst_state", out_state, 128'h0);
      step();
      rst = 1'b0;
      step();
      chk("mid_rst_in_ready", in_ready, 128'd1);
      in_valid  = 1'b1;
      sub_state = R1_SUB;
      round_key = R1_KEY;
      step();
      chk("after_rst_state", out_state, R1_OUT);
      chk("after_rst_last", out_last, 128'd0);
      chk("after_rst_round_idx", round_idx, 128'd2);

      // Streaming: 20 back-to-back beats from round 1
      in_valid = 1'b0;
      rst = 1'b1;
      #1 rst = 1'b0;
      chk("stream_start_round_idx", round_idx, 128'd1);
      in_valid  = 1'b1;
      round_key = {16{8'h3C}};
      for (int k = 1; k <= 20; k++) begin
         b = 8'(k);
         sub_state = {16{b}};
         #1;
         chk("stream_in_ready", in_ready, 128'd1);
         step();
         chk("stream_valid", out_valid, 128'd1);
         chk("stream_state", out_state, {16{b ^ 8'h3C}});
         chk("stream_last", out_last, (k % 10 == 0) ? 128'd1 : 128'd0);
      end
      chk("stream_end_round_idx", round_idx, 128'd1);
      in_valid = 1'b0;
      step();
      chk("stream_drain_valid", out_valid, 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/shift_mix_key_stage.md
SHIFT_MIX_KEY_STAGE -- requirements
Module: shift_mix_key_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: sub_state and round_key valid this cycle.
REQ-004 SHALL have port in_ready, output, 1 bit: stage can accept a beat this cycle.
REQ-005 SHALL have port sub_state, input, 128 bits: byte-substituted AES state from the SubBytes stage.
REQ-006 SHALL have port round_key, input, 128 bits: round key paired with sub_state.
REQ-007 SHALL have port out_valid, output, 1 bit: out_state holds a result.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts out_state this cycle.
REQ-009 SHALL have port out_state, output, 128 bits: result of ShiftRows, MixColumns (when applicable) and AddRoundKey.
REQ-010 SHALL have port out_last, output, 1 bit: out_state is the final-round ciphertext.
REQ-011 SHALL have port round_idx, output, 4 bits: round number (1..10) of the next beat to be accepted.

Function
REQ-012 SHALL use byte order byte0 = [127:120] through byte15 = [7:0], column-major: byte index = 4*col + row.
REQ-013 SHALL apply ShiftRows by rotating row r left by r columns, r = 0..3.
REQ-014 SHALL apply MixColumns per column with matrix rows {02 03 01 01} rotated, using GF(2^8) xtime with reduction constant 0x1B.
REQ-015 SHALL bypass MixColumns when round_idx = 10.
REQ-016 SHALL XOR the round_key into the result (AddRoundKey) after ShiftRows and MixColumns.
REQ-017 SHALL accept a beat when in_valid && in_ready.
REQ-018 SHALL drive in_ready = !out_valid || out_ready, giving full throughput with one output register.
REQ-019 SHALL, on accept, register out_state, set out_valid = 1 and set out_last = (round_idx == 10); latency is 1 cycle from accept to out_valid.
REQ-020 SHALL clear out_valid on out_valid && out_ready when no beat is accepted in the same cycle.
REQ-021 SHALL, when output handoff and a new accept occur in the same cycle, load the new result and keep out_valid = 1.
REQ-022 SHALL hold out_state, out_last and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL increment round_idx on each accept, wrapping from 10 to 1.
REQ-024 SHALL leave round_idx unchanged on cycles without an accept.
REQ-025 SHALL never present round_idx values 0 or 11..15.

Reset
REQ-026 SHALL, on rst assertion and independent of clk, force out_valid = 0, out_last = 0, out_state = 128'h0 and round_idx = 1.
REQ-027 SHALL, when rst asserts mid-block, discard the in-flight result; after release the next accepted beat is round 1.
REQ-028 SHALL drive in_ready = 1 on the first cycle after reset release.

Structure
REQ-029 SHALL take the constants NUM_ROUNDS = 10 and GF_POLY = 8'h1B, and the state/column typedefs, from the shared aes package.
REQ-030 SHALL implement the per-column MixColumns function as one sub-module, mix_column (32-bit in, 32-bit out), instantiated 4 times.
REQ-031 SHALL keep the ShiftRows and MixColumns datapath combinational; only the output register, out_valid, out_last and round_idx are stateful.

Verification
REQ-032 SHALL check the MixColumns unit: column db 13 53 45 -> 8e 4d a1 bc.
REQ-033 SHALL check the FIPS-197 App. B round 1: sub_state d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 with round_key a0 fa fe 17 88 54 2c b1 23 a3 39 39 2a 6c 76 05 -> out_state a4 9c 7f f2 68 9f 35 2b 6b 5b ea 43 02 6a 50 49 with out_last = 0.
REQ-034 SHALL check the full FIPS-197 10-round sequence: the 10th beat bypasses MixColumns, out_state = 39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32, out_last = 1, and round_idx returns to 1.
REQ-035 SHALL check backpressure: out_ready = 0 for 5 cycles with in_valid = 1 -> in_ready = 0, outputs stable, round_idx frozen; on out_ready = 1, handoff and accept occur in the same cycle.
REQ-036 SHALL check reset mid-block: assert rst after round 4 -> out_valid = 0 immediately and round_idx = 1; the next beat is treated as round 1.
REQ-037 SHALL check streaming: in_valid = out_ready = 1 for 20 cycles -> 20 results, one per cycle, with out_last on beats 10 and 20.
